// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one memory port between fetch and load/store,
// with fetch starvation protection and a bus timeout.
module memory_bus_arbiter #(
    parameter int X_LENGTH     = 32,
    parameter int MEMORY_WIDTH = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_req,
    input  logic [X_LENGTH-1:0]       if_addr,
    output logic                      if_ready,
    output logic [MEMORY_WIDTH-1:0]   if_rdata,
    input  logic                      ls_req,
    input  logic                      ls_we,
    input  logic [X_LENGTH-1:0]       ls_addr,
    input  logic [MEMORY_WIDTH-1:0]   ls_wdata,
    input  logic [MEMORY_WIDTH/8-1:0] ls_wstrb,
    output logic                      ls_ready,
    output logic [MEMORY_WIDTH-1:0]   ls_rdata,
    output logic                      bus_error,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [X_LENGTH-1:0]       mem_addr,
    output logic [MEMORY_WIDTH-1:0]   mem_wdata,
    output logic [MEMORY_WIDTH/8-1:0] mem_wstrb,
    input  logic                      mem_ack,
    input  logic [MEMORY_WIDTH-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t     state, state_next;
    logic       winner_ls;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    logic       any_req, contested, pick_ls, timed_out, finish;

    always_comb begin
        any_req    = if_req || ls_req;
        contested  = if_req && ls_req;
        pick_ls    = ls_req && !(if_req && starve_cnt == 4'(STARVE_LIMIT));
        // an ack in the final allowed cycle wins over the timeout
        timed_out  = !mem_ack && tmo_cnt == 8'(TIMEOUT - 1);
        finish     = mem_ack || timed_out;
        state_next = state;
        case (state)
            IDLE:    state_next = any_req ? GRANT : IDLE;
            GRANT:   state_next = finish ? DONE : GRANT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_ls  <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            if_ready   <= 1'b0;
            ls_ready   <= 1'b0;
            bus_error  <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            if_ready  <= 1'b0;
            ls_ready  <= 1'b0;
            bus_error <= 1'b0;
            if (state == IDLE && any_req) begin
                winner_ls  <= pick_ls;
                mem_req    <= 1'b1;
                mem_we     <= pick_ls && ls_we;
                mem_addr   <= pick_ls ? ls_addr : if_addr;
                mem_wdata  <= pick_ls ? ls_wdata : '0;
                mem_wstrb  <= pick_ls ? ls_wstrb : '0;
                tmo_cnt    <= '0;
                // a contested ls win is only possible below the limit, so +1 never overflows it
                starve_cnt <= pick_ls ? starve_cnt + 4'(contested) : '0;
            end
            if (state == GRANT) begin
                if (finish) begin
                    mem_req   <= 1'b0;
                    if_ready  <= !winner_ls;
                    ls_ready  <= winner_ls;
                    bus_error <= timed_out;
                    if (!winner_ls)
                        if_rdata <= mem_ack ? mem_rdata : '0;
                    else if (!mem_we || timed_out)
                        ls_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed checks of arbitration, starvation,
// timeout, spurious acks and asynchronous reset.
module tb_memory_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        bus_error, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("wait_req", 64'(mem_req), 64'd1);
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_ctl"}, 64'({if_ready, ls_ready, bus_error, mem_req, mem_we, mem_wstrb}), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_data"}, {if_rdata, ls_rdata} | 64'(mem_wdata), 64'd0);
    endtask

    logic [31:0] exp_addr [6];
    logic        exp_ls   [6];
    int          hi_cnt, readys;

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0;
        ls_addr = 0; ls_wdata = 0; ls_wstrb = 0; mem_ack = 0; mem_rdata = 0;
        tick(); tick();
        all_zero("reset");
        rst_n = 1'b1;
        tick();

        // single fetch
        if_req = 1; if_addr = 32'h100;
        tick();
        check("fetch_req", 64'(mem_req), 64'd1);
        check("fetch_addr", 64'(mem_addr), 64'h100);
        check("fetch_we", 64'(mem_we), 64'd0);
        mem_ack = 1; mem_rdata = 32'h13;
        tick();
        mem_ack = 0;
        check("fetch_ready", 64'({if_ready, ls_ready, bus_error}), 64'b100);
        check("fetch_rdata", 64'(if_rdata), 64'h13);
        check("fetch_req_low", 64'(mem_req), 64'd0);
        tick();
        if_req = 0;

        // plain load
        ls_req = 1; ls_we = 0; ls_addr = 32'h300;
        wait_req();
        check("load_addr", 64'(mem_addr), 64'h300);
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 0;
        check("load_ready", 64'({if_ready, ls_ready, bus_error}), 64'b010);
        check("load_rdata", 64'(ls_rdata), 64'hCAFEF00D);
        tick();
        ls_req = 0;

        // contention: store wins, then fetch
        if_req = 1; if_addr = 32'h200;
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_wstrb = 4'hF;
        tick();
        check("cont_store_addr", 64'(mem_addr), 64'h2000);
        check("cont_store_we", 64'({mem_we, mem_wstrb}), 64'h1F);
        check("cont_store_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        mem_ack = 1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 0;
        check("cont_store_ready", 64'({if_ready, ls_ready, bus_error}), 64'b010);
        check("cont_store_rdata", 64'(ls_rdata), 64'hCAFEF00D);
        tick();
        ls_req = 0;
        tick();
        check("cont_fetch_addr", 64'(mem_addr), 64'h200);
        check("cont_fetch_we", 64'({mem_we, mem_wstrb}), 64'h0);
        mem_ack = 1; mem_rdata = 32'h0000AAAA;
        tick();
        mem_ack = 0;
        check("cont_fetch_ready", 64'({if_ready, ls_ready}), 64'b10);
        tick();
        if_req = 0; ls_we = 0;

        // starvation: four ls wins, one fetch, then ls again
        exp_addr = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h400, 32'h500};
        exp_ls   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        if_req = 1; if_addr = 32'h400;
        ls_req = 1; ls_addr = 32'h500;
        for (int i = 0; i < 6; i++) begin
            wait_req();
            check($sformatf("starve_addr%0d", i), 64'(mem_addr), 64'(exp_addr[i]));
            mem_ack = 1; mem_rdata = 32'h1000 + 32'(i);
            tick();
            mem_ack = 0;
            check($sformatf("starve_ready%0d", i), 64'({if_ready, ls_ready}),
                  exp_ls[i] ? 64'b01 : 64'b10);
        end
        tick();
        if_req = 0; ls_req = 0;
        check("starve_ls_rdata", 64'(ls_rdata), 64'h1005);

        // timeout on a load
        ls_req = 1; ls_addr = 32'h600;
        wait_req();
        hi_cnt = 0;
        while (mem_req && hi_cnt < 40) begin
            hi_cnt++;
            tick();
        end
        check("tmo_req_cycles", 64'(hi_cnt), 64'd16);
        check("tmo_ready", 64'({if_ready, ls_ready, bus_error}), 64'b011);
        check("tmo_rdata", 64'(ls_rdata), 64'd0);
        tick();
        check("tmo_err_clear", 64'({ls_ready, bus_error}), 64'd0);
        ls_req = 0;
        tick();
        ls_req = 1; ls_addr = 32'h700;
        wait_req();
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_ack = 0;
        check("after_tmo_ready", 64'({if_ready, ls_ready, bus_error}), 64'b010);
        check("after_tmo_rdata", 64'(ls_rdata), 64'hA5A5A5A5);
        tick();
        ls_req = 0;

        // ack in the last allowed cycle is a success
        if_req = 1; if_addr = 32'h800;
        wait_req();
        for (int i = 0; i < 15; i++) tick();
        check("edge_req_high", 64'(mem_req), 64'd1);
        mem_ack = 1; mem_rdata = 32'h77;
        tick();
        mem_ack = 0;
        check("edge_ready", 64'({if_ready, ls_ready, bus_error}), 64'b100);
        check("edge_rdata", 64'(if_rdata), 64'h77);
        tick();
        if_req = 0;

        // spurious ack in IDLE
        tick();
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 0;
        tick();
        check("spur_idle_ctl", 64'({if_ready, ls_ready, mem_req}), 64'd0);
        check("spur_idle_data", {if_rdata, ls_rdata}, {32'h77, 32'hA5A5A5A5});

        // ack held into DONE
        if_req = 1; if_addr = 32'h900;
        wait_req();
        mem_ack = 1; mem_rdata = 32'h11;
        tick();
        mem_rdata = 32'h22;
        check("spur_done_ready", 64'(if_ready), 64'd1);
        tick();
        if_req = 0;
        check("spur_done_after", 64'({if_ready, ls_ready, mem_req}), 64'd0);
        check("spur_done_rdata", 64'(if_rdata), 64'h11);
        mem_ack = 0;
        tick();

        // asynchronous reset mid-GRANT
        ls_req = 1; ls_we = 1; ls_addr = 32'hA00; ls_wdata = 32'h55; ls_wstrb = 4'h3;
        wait_req();
        #2 rst_n = 1'b0;
        #1 all_zero("rst_mid");
        ls_req = 0; ls_we = 0;
        #1 rst_n = 1'b1;
        readys = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            readys += int'(if_ready) + int'(ls_ready) + int'(mem_req);
        end
        check("rst_no_ready", 64'(readys), 64'd0);
        if_req = 1; if_addr = 32'hB00;
        wait_req();
        check("rst_next_addr", 64'(mem_addr), 64'hB00);
        mem_ack = 1; mem_rdata = 32'h33;
        tick();
        mem_ack = 0;
        check("rst_next_ready", 64'({if_ready, ls_ready, bus_error}), 64'b100);
        check("rst_next_rdata", 64'(if_rdata), 64'h33);
        tick();
        if_req = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares the single memory bus between the instruction fetch path and the execute unit's load/store path (`rv32_s_*` / `rv32_i_l*` instructions). It arbitrates requests and drives a one-outstanding-transaction memory port. It returns read data or write completion to the winning requester, with starvation protection for fetch and a bus timeout. It sits between the fetch/execute units and the memory controller, and it is the only source of `memory_read_data` delivery to the execute unit.

## Interface
- `X_LENGTH`, 32: address width.
- `MEMORY_WIDTH`, 32: data width; byte strobes are `MEMORY_WIDTH/8` bits.
- `STARVE_LIMIT`, 4: consecutive contested load/store wins before fetch is forced to win; range 1..15.
- `TIMEOUT`, 16: cycles `mem_req` may stay high without `mem_ack` before abort; range 2..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, level.
- `if_addr`  in  X_LENGTH  fetch address.
- `if_ready`  out  1  one-cycle completion pulse to fetch.
- `if_rdata`  out  MEMORY_WIDTH  fetched word.
- `ls_req`  in  1  load/store request, level.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  X_LENGTH  load/store address.
- `ls_wdata`  in  MEMORY_WIDTH  store data.
- `ls_wstrb`  in  MEMORY_WIDTH/8  store byte enables.
- `ls_ready`  out  1  one-cycle completion pulse to load/store.
- `ls_rdata`  out  MEMORY_WIDTH  load data.
- `bus_error`  out  1  high with `if_ready` or `ls_ready` when the transaction timed out.
- `mem_req`  out  1  memory request, held until ack or timeout.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/X_LENGTH/MEMORY_WIDTH/MEMORY_WIDTH/8  registered transaction fields.
- `mem_ack`  in  1  memory completion, one cycle.
- `mem_rdata`  in  MEMORY_WIDTH  read data, valid with `mem_ack`.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - GRANT: `mem_req`=1, wait for ack.
  - DONE: ready pulse, no arbitration.
- Transitions:
  - IDLE→GRANT when any request is present.
  - GRANT→DONE on `mem_ack` or timeout.
  - DONE→IDLE always.
- Arbitration in IDLE:
  - Only one request present: that requester wins.
  - Both present: load/store wins, unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- `starve_cnt`:
  - Increments, saturating at `STARVE_LIMIT`, on each contested load/store win.
  - Clears whenever fetch wins.
  - Uncontested load/store wins leave it unchanged.
- On grant:
  - Latch winner id. Fetch grants force `mem_we`=0 and `mem_wstrb`=0.
  - Latch `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb` from the winner.
  - Clear the timeout counter.
- GRANT, cycle with `mem_ack`=1: capture `mem_rdata` into the winner's rdata (load/store: loads only; store completions leave `ls_rdata` unchanged). Go to DONE.
- GRANT without ack: increment the timeout counter. When it reaches `TIMEOUT`, abort:
  - drop `mem_req`,
  - winner's rdata := 0,
  - `bus_error` := 1 in DONE.
- DONE: the winner's ready = 1 for exactly one cycle; `bus_error` is valid only in this cycle.
- `mem_ack` outside GRANT is ignored.
- Requesters hold req and all fields stable from assertion through their ready cycle. They may drop or change them from the following cycle.
- Reset (asynchronous, any state) forces state IDLE, counters 0, and every output to 0. Any in-flight transaction is discarded; no ready is generated for it.

## Timing
- All outputs are registered. Cycle numbers are relative to cycle 0 (IDLE with req seen):
  - `mem_req` and mem fields valid from cycle 1.
  - Ack in cycle k (k≥1) → ready in cycle k+1 and `mem_req` low in cycle k+1.
- Minimum latency from req to ready is 2 cycles. Minimum transaction spacing is 3 cycles.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles (1..TIMEOUT). Ready with `bus_error` follows in cycle TIMEOUT+1.
- Ack arriving in the same cycle the counter reaches `TIMEOUT` counts as success.
- Request fields are sampled only at the IDLE→GRANT edge.

## Test plan
- Reset: assert `rst_n`=0 mid-GRANT → all outputs 0 immediately. After release, no ready pulse appears and the next request is granted normally.
- Single fetch: `if_addr`=0x100, ack in cycle 1 with `mem_rdata`=0x00000013 → `mem_addr`=0x100, `mem_we`=0 in cycle 1; `if_ready`=1 and `if_rdata`=0x13 in cycle 2; `mem_req`=0 in cycle 2.
- Contention: in cycle 0, present fetch 0x200 together with store `ls_addr`=0x2000, `ls_wdata`=0xDEADBEEF, `ls_wstrb`=0xF → store granted first with `mem_we`=1 and `mem_wstrb`=0xF. Fetch is granted in the next IDLE; `ls_rdata` is unchanged.
- Starvation, `STARVE_LIMIT`=4: hold `if_req` and `ls_req` continuously with acks in 1 cycle → 4 load/store grants, then the 5th grant goes to fetch, then load/store wins again.
- Timeout, `TIMEOUT`=16: load with no ack → `mem_req` high for 16 cycles, then `ls_ready`=1, `bus_error`=1, `ls_rdata`=0. A subsequent normal load completes with `bus_error`=0.
- Spurious ack: pulse `mem_ack` in IDLE and in DONE → no ready pulse, no rdata change.
